// File: rtl/aes128_type_pkg.sv
// Shared AES-128 types and pure transforms used by the cipher core and key expansion.
// Byte 0 of a state is bits [127:120]; bytes run column-major.
package aes128_type_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [3:0]   round_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } cipher_state_e;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        // ~b is 255-b, so this shifts entry b down into the low byte.
        return 8'(SBOX_TABLE >> {~b, 3'b000});
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        return {s[127:120], s[87:80],   s[47:40],  s[7:0],
                s[95:88],   s[55:48],   s[15:8],   s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],  s[39:32]};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]),  mix_column(s[31:0])};
    endfunction

endpackage

// File: rtl/aes128_sbox.sv
// Single-byte combinational AES forward S-box.
module aes128_sbox
    import aes128_type_pkg::*;
(
    input  logic [7:0] plain_byte,
    output logic [7:0] sub_byte
);

    assign sub_byte = sbox_byte(plain_byte);

endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption: AddRoundKey / ShiftRows / MixColumns per key,
// SubBytes serialised over SBOX_LANES S-boxes between keys.
module aes128_cipher_core
    import aes128_type_pkg::*;
#(
    parameter int SBOX_LANES = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [127:0] data_i,
    input  logic [127:0] round_key_i,
    input  logic         key_valid_i,
    output logic         key_req_o,
    output logic [127:0] data_o,
    output logic         valid_o,
    output logic         busy_o
);

    localparam int GROUPS = 16 / SBOX_LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(GROUPS - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $fatal(1, "aes128_cipher_core: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    cipher_state_e    fsm;
    aes_state_t       st;
    round_t           round;
    logic [CNT_W-1:0] byte_cnt;

    logic [7:0] st_bytes [16];
    logic [7:0] lane_in  [SBOX_LANES];
    logic [7:0] lane_out [SBOX_LANES];
    logic [3:0] grp_base;
    aes_state_t sub_state;
    aes_state_t key_mix;

    assign grp_base = 4'(int'(byte_cnt) * SBOX_LANES);

    for (genvar g = 0; g < 16; g++) begin : g_bytes
        assign st_bytes[g] = st[127 - 8*g -: 8];
        assign sub_state[127 - 8*g -: 8] = (byte_cnt == CNT_W'(g / SBOX_LANES))
                                         ? lane_out[g % SBOX_LANES] : st_bytes[g];
    end

    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lanes
        assign lane_in[l] = st_bytes[grp_base + 4'(l)];
        aes128_sbox u_sbox (
            .plain_byte (lane_in[l]),
            .sub_byte   (lane_out[l])
        );
    end

    // SubBytes of the previous round has already been applied in SUB, so the
    // key step only needs the linear layer for the round being closed.
    always_comb begin
        if (round == '0) begin
            key_mix = st ^ round_key_i;
        end else if (round == LAST_ROUND) begin
            key_mix = shift_rows(st) ^ round_key_i;
        end else begin
            key_mix = mix_columns(shift_rows(st)) ^ round_key_i;
        end
    end

    // Key handshake: round_key_i is taken on any KEY-state edge with key_valid_i
    // high; key_req_o pulses the cycle after to ask for the next key. SUB always
    // separates two KEY samples, so a lingering valid is never reused.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm       <= IDLE;
            st        <= '0;
            round     <= '0;
            byte_cnt  <= '0;
            key_req_o <= 1'b0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            data_o    <= '0;
        end else begin
            key_req_o <= 1'b0;
            valid_o   <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        st     <= data_i;
                        round  <= '0;
                        busy_o <= 1'b1;
                        fsm    <= KEY;
                    end
                end
                KEY: begin
                    if (key_valid_i) begin
                        st <= key_mix;
                        if (round == LAST_ROUND) begin
                            data_o  <= key_mix;
                            valid_o <= 1'b1;
                            fsm     <= DONE;
                        end else begin
                            key_req_o <= 1'b1;
                            round     <= round + 4'd1;
                            byte_cnt  <= '0;
                            fsm       <= SUB;
                        end
                    end
                end
                SUB: begin
                    st <= sub_state;
                    if (byte_cnt == LAST_GROUP) begin
                        fsm <= KEY;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Bench for aes128_cipher_core at SBOX_LANES 16, 4 and 1 against a byte-level
// AES reference that derives its S-box from GF(2^8) inversion.
module tb_aes128_cipher_core;

    localparam int NDUT = 3;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    function automatic int lanes_of(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start   [NDUT];
    logic [127:0] data    [NDUT];
    logic [127:0] rkey    [NDUT];
    logic         kvalid  [NDUT];
    logic         key_req [NDUT];
    logic [127:0] dout    [NDUT];
    logic         valid   [NDUT];
    logic         busy    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LN = lanes_of(g);
        aes128_cipher_core #(.SBOX_LANES(LN)) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .start_i     (start[g]),
            .data_i      (data[g]),
            .round_key_i (rkey[g]),
            .key_valid_i (kvalid[g]),
            .key_req_o   (key_req[g]),
            .data_o      (dout[g]),
            .valid_o     (valid[g]),
            .busy_o      (busy[g])
        );
    end

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab   [NDUT][11];
    logic [127:0] last_ct  [NDUT];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return 8'(v >> (8 * (15 - i)));
    endfunction

    task automatic model(input int d, input logic [127:0] key, input logic [127:0] pt,
                         output logic [127:0] ct);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        logic [7:0]  b [16];
        logic [7:0]  t [16];
        logic [7:0]  a [4];
        int          cc, rw;
        for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_tab[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int i = 0; i < 16; i++) b[i] = byte_of(pt, i) ^ byte_of(rk_tab[d][0], i);
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) begin
                cc = i / 4;
                rw = i % 4;
                t[i] = sbox_tab[b[4 * ((cc + rw) % 4) + rw]];
            end
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = t[4*c+k];
                    for (int k = 0; k < 4; k++)
                        t[4*c+k] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03) ^ a[(k+2)%4] ^ a[(k+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) b[i] = t[i] ^ byte_of(rk_tab[d][r], i);
        end
        ct = '0;
        for (int i = 0; i < 16; i++) ct = (ct << 8) | 128'(b[i]);
    endtask

    // ---------------- driver: one block, acting as the key expander ----------------
    task automatic run_block(input int d, input logic [127:0] key, input logic [127:0] pt,
                             input bit stall_en, input bit inject, input int abort_at,
                             input string tag);
        logic [127:0] exp_ct;
        int cyc, nreq, kidx, rem, r, stall_sum, sub_extra, exp_lat;
        bit seen, busy_ok, hold_ok, aborted, quiet;
        model(d, key, pt, exp_ct);
        sub_extra = 16 / lanes_of(d) - 1;
        exp_lat   = 1 + 10 * (16 / lanes_of(d) + 1);
        r = stall_en ? int'($urandom_range(0, 7)) : 0;
        rem = r; stall_sum = r; kidx = 0; nreq = 0; cyc = -1;
        seen = 0; busy_ok = 1; hold_ok = 1; aborted = 0;
        data[d] = pt; start[d] = 1'b1; kvalid[d] = 1'b0; rkey[d] = rand128();
        while (!seen && !aborted && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start[d] = inject && (cyc == 5 || cyc == 12);
            data[d]  = rand128();
            if (abort_at > 0 && cyc == abort_at) begin
                aborted = 1;
            end else begin
                if (key_req[d]) begin
                    nreq++;
                    if (kidx < 10) kidx++;
                    r = stall_en ? int'($urandom_range(0, 7)) : 0;
                    rem = sub_extra + r;
                    stall_sum += r;
                    kvalid[d] = 1'b0;
                end else begin
                    kvalid[d] = (rem == 0);
                    if (rem > 0) rem--;
                end
                rkey[d] = kvalid[d] ? rk_tab[d][kidx] : rand128();
                if (busy[d] !== 1'b1) busy_ok = 0;
                if (valid[d] === 1'b1) seen = 1;
                else if (dout[d] !== last_ct[d]) hold_ok = 0;
            end
        end

        if (aborted) begin
            rst_n = 1'b0; start[d] = 1'b0; kvalid[d] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                #1;
                check({tag, " in-reset key_req"}, 128'(key_req[d]), 128'd0);
                check({tag, " in-reset valid"},   128'(valid[d]),   128'd0);
                check({tag, " in-reset busy"},    128'(busy[d]),    128'd0);
                check({tag, " in-reset data_o"},  dout[d],          128'd0);
                @(negedge clk);
            end
            rst_n = 1'b1;
            quiet = 1;
            repeat (6) begin
                @(negedge clk);
                if (key_req[d] !== 1'b0 || busy[d] !== 1'b0 || valid[d] !== 1'b0) quiet = 0;
            end
            check({tag, " quiet after reset"}, 128'(quiet), 128'd1);
            for (int k = 0; k < NDUT; k++) last_ct[k] = '0;
            return;
        end

        check({tag, " completed in bound"}, 128'(seen), 128'd1);
        check({tag, " ciphertext"}, dout[d], exp_ct);
        check({tag, " latency"}, 128'(cyc), 128'(exp_lat + stall_sum));
        check({tag, " key_req pulses"}, 128'(nreq), 128'd10);
        check({tag, " busy held"}, 128'(busy_ok), 128'd1);
        check({tag, " data_o held"}, 128'(hold_ok), 128'd1);
        if (inject) begin
            data[d] = rand128();
            start[d] = 1'b1;
        end
        @(negedge clk);
        start[d] = 1'b0; kvalid[d] = 1'b0;
        check({tag, " valid one cycle"}, 128'(valid[d]), 128'd0);
        check({tag, " idle after done"}, 128'(busy[d]), 128'd0);
        if (inject) begin
            @(negedge clk);
            check({tag, " start in DONE ignored"}, 128'(busy[d]), 128'd0);
        end
        last_ct[d] = exp_ct;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] ct;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            start[d] = 1'b0; data[d] = '0; rkey[d] = '0; kvalid[d] = 1'b0; last_ct[d] = '0;
        end
        build_sbox();
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset key_req", 128'(key_req[d]), 128'd0);
            check("reset valid",   128'(valid[d]),   128'd0);
            check("reset busy",    128'(busy[d]),    128'd0);
            check("reset data_o",  dout[d],          128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        model(0, KEY_B, PT_B, ct);
        check("model app B", ct, CT_B);
        model(0, KEY_C, PT_C, ct);
        check("model app C", ct, CT_C);

        run_block(0, KEY_B, PT_B, 1'b0, 1'b0, 0, "appB L16");
        check("appB L16 known answer", dout[0], CT_B);
        run_block(1, KEY_C, PT_C, 1'b0, 1'b0, 0, "appC L4");
        check("appC L4 known answer", dout[1], CT_C);
        run_block(2, KEY_C, PT_C, 1'b0, 1'b0, 0, "appC L1");
        check("appC L1 known answer", dout[2], CT_C);

        run_block(0, KEY_B, PT_B, 1'b1, 1'b0, 0, "appB stalls");
        run_block(0, KEY_B, PT_B, 1'b0, 1'b1, 0, "appB start while busy");

        run_block(0, KEY_C, PT_C, 1'b0, 1'b0, 10, "appC abort");
        run_block(0, KEY_C, PT_C, 1'b0, 1'b0, 0, "appC after reset");

        run_block(0, KEY_B, PT_B, 1'b0, 1'b0, 0, "b2b first");
        run_block(0, KEY_C, PT_C, 1'b0, 1'b0, 0, "b2b second");
        check("b2b second known answer", dout[0], CT_C);

        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 2; n++) begin
                run_block(d, rand128(), rand128(), 1'b1, 1'b0, 0, "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_cipher_core.md
Name: aes128_cipher_core

Overview:
- Iterative AES-128 encryption datapath. It is the consumer directly downstream of aes128_key_expansion.
- Latches a 128-bit plaintext block and requests round keys one at a time over the key_req/valid handshake. It runs 10 rounds and presents the ciphertext.
- SubBytes is serialised over a configurable number of S-box lanes to trade area for latency.
- The top level pulses start to both this block and the key expander in the same cycle.

Parameters:
- SBOX_LANES, default 16: S-box instances. Bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a fatal elaboration error.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- start_i  input  1  single-cycle pulse; latch data_i and begin encryption
- data_i  input  128  plaintext; byte 0 at [127:120], column-major as FIPS-197
- round_key_i  input  128  current round key from key expansion
- key_valid_i  input  1  round_key_i is valid
- key_req_o  output  1  one-cycle pulse; current key consumed, next key requested
- data_o  output  128  ciphertext; held until the next completion
- valid_o  output  1  one-cycle pulse; data_o updated
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is asynchronous, active-low. All flops clear on reset assertion.
- Reset values: key_req_o=0, valid_o=0, busy_o=0, data_o=0. Internally, state register=0, round=0, byte counter=0, FSM=IDLE.
- Round counter: 4 bits, range 0..10.
- Byte counter: range 0..16/SBOX_LANES-1.
- FSM states are IDLE, KEY, SUB, DONE.
- IDLE:
  - On start_i, state <= data_i and round <= 0; go to KEY.
  - Otherwise stay.
- KEY (sample key_valid_i):
  - If key_valid_i=0, hold; no key_req_o.
  - If key_valid_i=1, consume round_key_i as follows:
    - round 0: state <= state ^ key
    - rounds 1..9: state <= MixColumns(ShiftRows(state)) ^ key
    - round 10: state <= ShiftRows(state) ^ key
  - After consuming with round<10: key_req_o is high for exactly the next cycle (registered). Go to SUB, round <= round+1, byte counter <= 0.
  - After consuming with round==10: no key_req_o. Go to DONE; data_o <= the new state, i.e. ShiftRows(state) ^ round_key_i, the final ciphertext.
- SUB:
  - Each cycle, substitute SBOX_LANES consecutive bytes, starting at byte counter*SBOX_LANES (byte 0 = [127:120]).
  - When the last group is done, go to KEY.
  - SUB always lasts at least 1 cycle. key_valid_i is therefore never sampled in the cycle key_req_o is high, so the stale valid from the previous key is never reused.
- DONE: valid_o high for this one cycle; return to IDLE. busy_o is high in DONE.
- Key handshake totals: exactly 11 keys consumed and exactly 10 key_req_o pulses per block.
- Latency with key_valid_i always ready: valid_o rises 1 + 10*(16/SBOX_LANES + 1) cycles after the edge sampling start_i. That is 21 cycles for SBOX_LANES=16 and 171 cycles for SBOX_LANES=1.
- Key stalls: each cycle key_valid_i is low in KEY adds one cycle; there is no timeout.
- start_i while busy_o=1 is ignored; it does not restart and does not corrupt state.
- start_i in the same cycle as valid_o (DONE) is ignored. start_i is accepted in IDLE only.
- data_i is sampled only at start; changes afterwards have no effect.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared, no further key_req_o. The key expander must be restarted by the top level.
- data_o is unchanged between completions.

Decomposition:
- aes128_type_pkg additions:
  - NUM_ROUNDS=10 and a round counter typedef
  - the aes_state_t 128-bit typedef
  - the FSM enum cipher_state_e
  - pure functions xtime, shift_rows, mix_columns and sbox_byte (table function, shared with key expansion)
- One sub-module: aes128_sbox, a single-byte combinational S-box wrapping sbox_byte. It is instantiated SBOX_LANES times in a generate loop.

Test Plan:
- FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, keys always valid, SBOX_LANES=16 -> data_o=3925841d02dc09fbdc118597196a0b32; valid_o exactly 21 cycles after start; 10 key_req_o pulses.
- FIPS-197 App. C.1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, SBOX_LANES=1 and 4 -> 69c4e0d86a7b0430d8cdb78070b4c55a; latency 171 and 51 cycles respectively.
- Random key_valid_i stalls of 0-7 cycles per round, App. B vector -> same ciphertext; no key consumed while valid is low; latency = 21 + total stall cycles.
- start_i pulsed at cycles 5 and 12 during an active encryption -> ignored; single valid_o with correct ciphertext; busy_o stays high throughout.
- rst_n_i asserted in round 5, then a fresh App. C.1 run -> outputs 0 while in reset; next run produces the correct ciphertext with no leftover key_req_o.
- Back-to-back blocks (start in the cycle after valid_o) with the App. B then App. C.1 vectors -> both ciphertexts correct; data_o holds the first result until the second valid_o.
